serial_parallel_rx: RTL and testbench
=====================================

# serial_parallel_rx

Single-lane deserializer for the PHY receive path: takes one serial lane as driven by the transmit side (`out_tx_serial_0` or `out_tx_serial_1`), finds byte alignment from the idle comma 8'hBC, and emits aligned bytes with a valid flag. One instance per lane; the outputs feed the lane recombination logic ahead of the 8-to-32 converter.

## Interface
- `COMMA`, 8'hBC, idle/alignment character the transmitter sends when it has no valid data.
- `BC_COUNT`, 4, consecutive aligned commas required to declare the lane active; legal range 2..15.

- `clk`  in  1  bit-rate clock; one serial bit per rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `data_in`  in  1  serial lane input, MSB of each byte first.
- `data_out`  out  8  last received non-comma byte.
- `valid_out`  out  1  high while `data_out` holds a byte received in the current byte period.
- `active`  out  1  lane aligned and passing data.
- `rx_byte_count`  out  16  valid bytes received; present only with `SP_RX_STATS_EN`.

## Operation
- Shift register `sr[7:0]`: `sr <= {sr[6:0], data_in}` on every edge. Candidate byte at an edge is `{sr[6:0], data_in}`.
- 3-bit bit counter `bit_cnt`; the edge with `bit_cnt == 7` is a byte edge. Counter free-runs (wraps 7 -> 0) outside SEARCH.
- States:
  - SEARCH: candidate compared against `COMMA` every edge (bit-level sliding). On match -> SYNC, `bc_cnt <= 1`, `bit_cnt <= 0`.
  - SYNC: on each byte edge, candidate == `COMMA` -> `bc_cnt <= bc_cnt + 1`; when the incremented value equals `BC_COUNT` -> ACTIVE, `active <= 1`. Candidate != `COMMA` -> SEARCH, `bc_cnt <= 0`.
  - ACTIVE: on each byte edge, candidate == `COMMA` -> `valid_out <= 0`, `data_out` holds; otherwise `data_out <= candidate`, `valid_out <= 1`. No exit except reset.
- `data_out`/`valid_out` change only on byte edges in ACTIVE; held constant for 8 cycles.
- `valid_out` is 0 in SEARCH and SYNC.

## Timing
- Reset (asserted low, asynchronous): state SEARCH, `sr = 0`, `bit_cnt = 0`, `bc_cnt = 0`, `data_out = 8'h00`, `valid_out = 0`, `active = 0`, `rx_byte_count = 0`. Reset mid-ACTIVE discards alignment; full re-acquisition required.
- Alignment: first comma detected on the edge sampling its 8th bit; `active` rises on the edge sampling the last bit of comma number `BC_COUNT`, i.e. 8*`BC_COUNT` cycles after the first comma bit when the stream starts aligned.
- Data latency: `data_out`/`valid_out` update on the edge sampling the byte's 8th bit (8 cycles from its first bit, no added pipeline stage).
- A comma pattern straddling byte boundaries in ACTIVE is ignored; only byte-edge candidates are decoded.
- Reset deassertion is registered by all flops on the next rising edge; no data sampled while `reset` low.

## Configuration
- `SP_RX_STATS_EN` defined: `rx_byte_count` port and a 16-bit counter exist; increments on each byte edge that sets `valid_out = 1`; saturates at 16'hFFFF; cleared only by reset.
- Not defined: port and counter absent; all other behaviour identical.

## Test plan
- Reset: hold `reset` low 3 cycles while driving random bits -> `data_out = 8'h00`, `valid_out = 0`, `active = 0` throughout.
- Aligned lock: 4x 8'hBC then 8'h5A, 8'hC3 -> `active` rises on the 32nd edge; `data_out = 8'h5A`, `valid_out = 1` on the 40th edge; `8'hC3` on the 48th.
- Misaligned start: 3 bits `101` then 4x 8'hBC then 8'h5A -> lock on the true boundary, `data_out = 8'h5A` on edge 43.
- Broken sync: 2x 8'hBC, 8'h11, then 4x 8'hBC, 8'h22 -> `active` stays 0 through 8'h11; rises after the later 4 commas; `data_out = 8'h22`, 8'h11 never output.
- Idle in ACTIVE: after lock send 8'hA5, 8'hBC, 8'h3C -> `valid_out` 1, 0, 1; `data_out` 8'hA5, 8'hA5, 8'h3C. With `SP_RX_STATS_EN`, `rx_byte_count = 2`.
- Reset mid-ACTIVE: pulse `reset` low for 1 cycle, then send 8'h77 -> all outputs zero, 8'h77 not output until 4 new commas received.

Source files
------------

// File: rtl/serial_parallel_rx_if.sv
// Receive-lane bundle between a serial source and serial_parallel_rx.
// rx_byte_count is present only when SP_RX_STATS_EN is defined.
interface serial_parallel_rx_if;
  logic        data_in;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        active;
`ifdef SP_RX_STATS_EN
  logic [15:0] rx_byte_count;

  modport master (output data_in, input data_out, input valid_out, input active,
                  input rx_byte_count);
  modport slave  (input data_in, output data_out, output valid_out, output active,
                  output rx_byte_count);
`else
  modport master (output data_in, input data_out, input valid_out, input active);
  modport slave  (input data_in, output data_out, output valid_out, output active);
`endif
endinterface

// File: rtl/serial_parallel_rx.sv
// Single-lane deserializer: comma-based byte alignment, aligned byte output with valid.
// Optional received-byte statistics counter enabled by defining SP_RX_STATS_EN.
module serial_parallel_rx #(
  parameter logic [7:0]  COMMA    = 8'hBC,
  parameter int unsigned BC_COUNT = 4
) (
  input  logic               clk,
  input  logic               reset,
  serial_parallel_rx_if.slave rx
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  localparam logic [3:0] BC_LOCK = 4'(BC_COUNT);

  state_e      state_q,   state_d;
  logic [7:0]  sr_q,      sr_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  bc_cnt_q,  bc_cnt_d;
  logic [7:0]  data_q,    data_d;
  logic        valid_q,   valid_d;
  logic        active_q,  active_d;
`ifdef SP_RX_STATS_EN
  logic [15:0] cnt_q,     cnt_d;
`endif

  logic [7:0]  cand_s;
  logic        byte_edge_s;
  logic        comma_s;
  logic [3:0]  bc_inc_s;

  assign cand_s      = {sr_q[6:0], rx.data_in};
  assign byte_edge_s = (bit_cnt_q == 3'd7);
  assign comma_s     = (cand_s == COMMA);
  assign bc_inc_s    = bc_cnt_q + 4'd1;

  // State register: every flop of the block, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_SEARCH;
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
      bc_cnt_q  <= 4'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
`ifdef SP_RX_STATS_EN
      cnt_q     <= 16'h0000;
`endif
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
`ifdef SP_RX_STATS_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // Next-state logic: bit-sliding search, byte-edge comma counting, then lock.
  always_comb begin
    state_d   = state_q;
    sr_d      = cand_s;
    bit_cnt_d = bit_cnt_q + 3'd1;
    bc_cnt_d  = bc_cnt_q;
    case (state_q)
      ST_SEARCH: begin
        // The counter is parked at zero until a comma pins the byte boundary.
        bit_cnt_d = 3'd0;
        if (comma_s) begin
          state_d  = ST_SYNC;
          bc_cnt_d = 4'd1;
        end else begin
          bc_cnt_d = 4'd0;
        end
      end
      ST_SYNC: begin
        if (byte_edge_s) begin
          if (comma_s) begin
            bc_cnt_d = bc_inc_s;
            if (bc_inc_s == BC_LOCK) begin
              state_d = ST_ACTIVE;
            end else begin
              state_d = ST_SYNC;
            end
          end else begin
            state_d  = ST_SEARCH;
            bc_cnt_d = 4'd0;
          end
        end else begin
          state_d = ST_SYNC;
        end
      end
      ST_ACTIVE: begin
        state_d = ST_ACTIVE;
      end
      default: begin
        state_d   = ST_SEARCH;
        bit_cnt_d = 3'd0;
        bc_cnt_d  = 4'd0;
      end
    endcase
  end

  // Output logic: byte outputs move only on byte edges while the lane is locked.
  always_comb begin
    data_d   = data_q;
    valid_d  = valid_q;
    active_d = (state_d == ST_ACTIVE);
`ifdef SP_RX_STATS_EN
    cnt_d    = cnt_q;
`endif
    if ((state_q == ST_ACTIVE) && byte_edge_s) begin
      if (comma_s) begin
        valid_d = 1'b0;
      end else begin
        data_d  = cand_s;
        valid_d = 1'b1;
`ifdef SP_RX_STATS_EN
        if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end else begin
          cnt_d = cnt_q;
        end
`endif
      end
    end else if (state_q != ST_ACTIVE) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  assign rx.data_out      = data_q;
  assign rx.valid_out     = valid_q;
  assign rx.active        = active_q;
`ifdef SP_RX_STATS_EN
  assign rx.rx_byte_count = cnt_q;
`endif

endmodule

// File: tb/tb_serial_parallel_rx.sv
// Directed bench for serial_parallel_rx: expected bytes queued at stimulus, checked at byte edges.
// Checks rx_byte_count too when SP_RX_STATS_EN is defined.
module tb_serial_parallel_rx;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  serial_parallel_rx_if bus ();

  serial_parallel_rx #(.COMMA(8'hBC), .BC_COUNT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_data;
  logic [15:0] exp_cnt;
  logic       pre_valid;
  logic       pre_active;
  logic [7:0] pre_data;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.data_in = b;
    @(posedge clk);
    #1;
  endtask

  // Snapshot taken after the 7th bit so byte-edge-only updates can be checked.
  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i]);
      if (i == 1) begin
        pre_valid  = bus.valid_out;
        pre_active = bus.active;
        pre_data   = bus.data_out;
      end
    end
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_q.push_back(b);
    send_byte(b);
    chk("data_hold", {8'h00, pre_data}, {8'h00, last_data});
    chk("valid_set", {15'h0, bus.valid_out}, 16'h0001);
    if (bus.valid_out === 1'b1 && exp_q.size() > 0) begin
      last_data = exp_q.pop_front();
      exp_cnt   = exp_cnt + 16'd1;
      chk("data_byte", {8'h00, bus.data_out}, {8'h00, last_data});
    end else begin
      chk("sb_pending", 16'(exp_q.size()), 16'd0);
    end
  endtask

  task automatic idle_comma();
    send_byte(8'hBC);
    chk("idle_valid", {15'h0, bus.valid_out}, 16'h0000);
    chk("idle_data", {8'h00, bus.data_out}, {8'h00, last_data});
  endtask

  task automatic lock_commas();
    for (int k = 0; k < 3; k++) begin
      send_byte(8'hBC);
      chk("pre_lock_active", {15'h0, bus.active}, 16'h0000);
    end
    send_byte(8'hBC);
    chk("lock_pre_edge", {15'h0, pre_active}, 16'h0000);
    chk("lock_active", {15'h0, bus.active}, 16'h0001);
    chk("lock_valid", {15'h0, bus.valid_out}, 16'h0000);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    chk("rst_async_active", {15'h0, bus.active}, 16'h0000);
    bus.data_in = 1'($urandom_range(1, 0));
    @(posedge clk);
    #1;
    chk("rst_data", {8'h00, bus.data_out}, 16'h0000);
    chk("rst_valid", {15'h0, bus.valid_out}, 16'h0000);
    chk("rst_active", {15'h0, bus.active}, 16'h0000);
    reset     = 1'b1;
    last_data = 8'h00;
    exp_cnt   = 16'h0000;
    exp_q.delete();
  endtask

  task automatic chk_stats();
`ifdef SP_RX_STATS_EN
    chk("byte_count", bus.rx_byte_count, exp_cnt);
`endif
  endtask

  initial begin
    reset       = 1'b0;
    bus.data_in = 1'b0;
    last_data   = 8'h00;
    exp_cnt     = 16'h0000;
    #2;
    // Reset held for 3 cycles with random line activity.
    for (int c = 0; c < 3; c++) begin
      bus.data_in = 1'($urandom_range(1, 0));
      @(posedge clk);
      #1;
      chk("reset_data", {8'h00, bus.data_out}, 16'h0000);
      chk("reset_valid", {15'h0, bus.valid_out}, 16'h0000);
      chk("reset_active", {15'h0, bus.active}, 16'h0000);
    end
    reset = 1'b1;

    // Aligned lock: active on edge 32, 5A on edge 40, C3 on edge 48.
    lock_commas();
    expect_byte(8'h5A);
    chk("pre_valid_first", {15'h0, pre_valid}, 16'h0000);
    expect_byte(8'hC3);
    chk_stats();

    // Misaligned start: 3 junk bits before the commas.
    pulse_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    lock_commas();
    expect_byte(8'h5A);

    // Broken sync: two commas, a data byte, then a full lock sequence.
    pulse_reset();
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h11);
    chk("broken_active", {15'h0, bus.active}, 16'h0000);
    chk("broken_data", {8'h00, bus.data_out}, 16'h0000);
    chk("broken_valid", {15'h0, bus.valid_out}, 16'h0000);
    lock_commas();
    expect_byte(8'h22);

    // Idle comma while locked, then a comma straddling a byte boundary.
    expect_byte(8'hA5);
    idle_comma();
    chk("idle_pre_valid", {15'h0, pre_valid}, 16'h0001);
    expect_byte(8'h3C);
    expect_byte(8'h0B);
    expect_byte(8'hC0);
    chk("still_active", {15'h0, bus.active}, 16'h0001);
    chk_stats();

    // Reset mid-ACTIVE discards alignment.
    pulse_reset();
    send_byte(8'h77);
    chk("relock_active", {15'h0, bus.active}, 16'h0000);
    chk("relock_valid", {15'h0, bus.valid_out}, 16'h0000);
    chk("relock_data", {8'h00, bus.data_out}, 16'h0000);
    lock_commas();
    expect_byte(8'h99);
    chk_stats();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
